// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two per-source FIFOs drained round-robin onto the register-file write port.
// Optional macro REGFILE_WB_DROP_X0_EN: accept x0 requests but never queue or issue them.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] writereg,
  output logic [DATA_WIDTH-1:0] writedata,
  output logic                  busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  logic [EW-1:0]         mem [2][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr [2];
  logic [PW-1:0]         rd_ptr [2];
  logic [CW-1:0]         count [2];
  logic [EW-1:0]         in_entry [2];
  logic [ADDR_WIDTH-1:0] in_addr [2];
  logic [1:0]            valid, ready, keep, push, nonempty, grant;
  src_e                  last_grant;

  assign valid       = {b_valid, a_valid};
  assign in_addr[0]  = a_addr;
  assign in_addr[1]  = b_addr;
  assign in_entry[0] = {a_addr, a_data};
  assign in_entry[1] = {b_addr, b_data};

`ifdef REGFILE_WB_DROP_X0_EN
  assign keep = {in_addr[1] != '0, in_addr[0] != '0};
`else
  assign keep = 2'b11;
`endif

  // Readiness looks only at the start-of-cycle count, so a full FIFO popping this cycle still refuses a push.
  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < 2; i++) begin
      ready[i]    = !reset && (count[i] < CW'(FIFO_DEPTH));
      nonempty[i] = count[i] != '0;
      push[i]     = valid[i] && ready[i] && keep[i];
    end
  end

  // Round-robin: on a tie the source not granted last wins.
  assign grant[0] = nonempty[0] && (!nonempty[1] || last_grant == SRC_B);
  assign grant[1] = nonempty[1] && !grant[0];

  assign a_ready = ready[0];
  assign b_ready = ready[1];
  assign busy    = (|nonempty) || wen;

  // NOTE: the storage array carries no reset; only pointers and counts define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      last_grant <= SRC_B;
      wen        <= 1'b0;
      writereg   <= '0;
      writedata  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
      end
      wen <= |grant;
      if (grant[0]) begin
        {writereg, writedata} <= mem[0][rd_ptr[0]];
        last_grant            <= SRC_A;
      end else if (grant[1]) begin
        {writereg, writedata} <= mem[1][rd_ptr[1]];
        last_grant            <= SRC_B;
      end
    end
  end

endmodule
